// File: rtl/float8_accumulator_pkg.sv
// Shared float8 accumulator definitions: number format constants, term width, FSM encoding.
// No logic; constants only.
// Imported by the unpack sub-module and the accumulator top.
package float8_accumulator_pkg;

    localparam int         FLOAT8_BIAS   = 7;
    localparam int         FLOAT8_FRAC   = 10;
    localparam logic [6:0] FLOAT8_MAXMAG = 7'h7F;

    // Largest term magnitude is 15<<15 (19 bits), so a signed term needs 20 bits to stay exact.
    localparam int TERM_W = 20;

    // Leading-one index p maps to biased exponent p - (FRAC - BIAS); p = 3..18 is the normal range.
    localparam logic [5:0] LOD_OFS = 6'(FLOAT8_FRAC - FLOAT8_BIAS);
    localparam logic [5:0] LOD_MAX = LOD_OFS + 6'd15;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_NORM  = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/float8_accumulator_if.sv
// Term-in / result-out handshake bundle for the float8 accumulator.
// No latency; wires only.
// Valid/ready both directions: iValid/oReady for terms, oValid/iReady for the result.
interface float8_accumulator_if;

    logic       iValid;
    logic       oReady;
    logic [7:0] iNum;
    logic       iOvf;
    logic       iLast;
    logic       oValid;
    logic       iReady;
    logic [7:0] oNum;
    logic       oOverflow;

    // Accumulator side
    modport slave (
        input  iValid, iNum, iOvf, iLast, iReady,
        output oReady, oValid, oNum, oOverflow
    );

    // Producer/consumer side
    modport master (
        output iValid, iNum, iOvf, iLast, iReady,
        input  oReady, oValid, oNum, oOverflow
    );

endinterface

// File: rtl/float8_accumulator_unpack.sv
// Exact float8 (1s/4e/3m, bias 7) to signed fixed point with 10 fraction bits.
// Combinational, zero latency.
// No handshake; pure function of the input byte.
module float8_unpack
    import float8_accumulator_pkg::*;
(
    input  logic [7:0]               i_num,
    output logic signed [TERM_W-1:0] o_term
);

    logic [TERM_W-1:0] w_mag;

    // Place the hidden-one significand at its binary weight; LSB weight is 2^-10. Both zeros map to 0.
    always_comb begin
        w_mag  = TERM_W'({1'b1, i_num[2:0]}) << i_num[6:3];
        o_term = '0;
        if (i_num[6:0] != 7'd0) begin
            o_term = i_num[7] ? -$signed(w_mag) : $signed(w_mag);
        end
    end

endmodule

// File: rtl/float8_accumulator.sv
// Sums a stream of float8 terms into a saturating fixed-point accumulator and repacks it to float8.
// Result valid 2 cycles after the iLast beat is presented (one NORM cycle), held until iReady.
// oReady only while accumulating; terms are refused during NORM/OUT. Option: FLOAT8_ACC_RELU_EN.
module float8_accumulator
    import float8_accumulator_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                 iClk,
    input  logic                 iRst,
    float8_accumulator_if.slave  bus
);

    localparam logic signed [ACC_W:0] SAT_POS = $signed({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_NEG = $signed({2'b11, {(ACC_W-2){1'b0}}, 1'b1});

    state_t r_state;
    state_t w_next_state;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_num;
    logic             r_num_ovf;

    logic                     w_accept;
    logic signed [TERM_W-1:0] w_term;
    logic signed [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]         w_acc_next;
    logic                     w_sat_hit;

    logic [ACC_W-1:0] w_abs;
    logic [5:0]       w_p;
    logic             w_sign;
    logic [3:0]       w_exp;
    logic [2:0]       w_mant;
    logic [7:0]       w_pack_num;
    logic             w_pack_ovf;

    float8_unpack u_unpack (
        .i_num  (bus.iNum),
        .o_term (w_term)
    );

    assign w_accept = bus.iValid && (r_state == ST_ACCUM);

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) r_state <= ST_ACCUM;
        else      r_state <= w_next_state;
    end

    // Next state: last accepted term starts normalisation; consumer handshake returns to accumulate
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && bus.iLast) w_next_state = ST_NORM;
            ST_NORM:  w_next_state = ST_OUT;
            ST_OUT:   if (bus.iReady) w_next_state = ST_ACCUM;
            default:  w_next_state = ST_ACCUM;
        endcase
    end

    // Handshake outputs decoded from state; result fields come straight from registers
    always_comb begin
        bus.oReady    = (r_state == ST_ACCUM);
        bus.oValid    = (r_state == ST_OUT);
        bus.oNum      = r_num;
        bus.oOverflow = r_num_ovf;
    end

    // One guard bit above the accumulator catches wrap; clamp symmetric so |acc| always fits ACC_W-1 bits
    always_comb begin
        w_sum      = $signed({r_acc[ACC_W-1], r_acc})
                   + $signed({{(ACC_W+1-TERM_W){w_term[TERM_W-1]}}, w_term});
        w_acc_next = w_sum[ACC_W-1:0];
        w_sat_hit  = 1'b0;
        if (w_sum > SAT_POS) begin
            w_acc_next = SAT_POS[ACC_W-1:0];
            w_sat_hit  = 1'b1;
        end else if (w_sum < SAT_NEG) begin
            w_acc_next = SAT_NEG[ACC_W-1:0];
            w_sat_hit  = 1'b1;
        end
    end

    // Sign/magnitude split and leading-one index of the magnitude (highest set bit wins)
    always_comb begin
        w_sign = r_acc[ACC_W-1];
        w_abs  = w_sign ? (~r_acc + 1'b1) : r_acc;
        w_p    = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_abs[i]) w_p = 6'(i);
        end
    end

    // Repack to float8: flush tiny values, clamp large/flagged ones, otherwise truncate the mantissa
    always_comb begin
        w_exp      = 4'(w_p - LOD_OFS);
        w_mant     = 3'(w_abs >> (w_p - LOD_OFS));
        w_pack_num = 8'h00;
        w_pack_ovf = r_ovf;
        if (w_abs == '0 || w_p < LOD_OFS) begin
            w_pack_num = 8'h00;
            w_pack_ovf = r_ovf;
        end else if (w_p > LOD_MAX || r_ovf) begin
            w_pack_num = {w_sign, FLOAT8_MAXMAG};
            w_pack_ovf = 1'b1;
        end else begin
            w_pack_num = (w_exp == 4'd0 && w_mant == 3'd0) ? 8'h00 : {w_sign, w_exp, w_mant};
            w_pack_ovf = 1'b0;
        end
`ifdef FLOAT8_ACC_RELU_EN
        // Negative sums clip to zero; an overflow flag survives the clip
        if (w_sign) w_pack_num = 8'h00;
`endif
    end

    // Accumulate accepted terms, capture the packed result in NORM, clear on consumption
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_num     <= 8'h00;
            r_num_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        if (w_sat_hit || bus.iOvf) r_ovf <= 1'b1;
                    end
                end
                ST_NORM: begin
                    r_num     <= w_pack_num;
                    r_num_ovf <= w_pack_ovf;
                end
                ST_OUT: begin
                    if (bus.iReady) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float8_accumulator.sv
// Directed self-checking bench for float8_accumulator with hand-computed float8 results.
// Expected latency: oValid visible 2 clock edges after the iLast beat is presented.
// Exercises hold under iReady=0, refused terms, and reset mid-sum.
module tb_float8_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    float8_accumulator_if bus();

    float8_accumulator #(.ACC_W(24)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Present one term for exactly one clock edge; state is ACCUM whenever this is called
    task automatic beat(input logic [7:0] n, input logic ovf, input logic last);
        @(negedge clk);
        bus.iValid = 1'b1;
        bus.iNum   = n;
        bus.iOvf   = ovf;
        bus.iLast  = last;
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        bus.iOvf   = 1'b0;
        bus.iLast  = 1'b0;
    endtask

    // Edges from the iLast beat's presentation until oValid is seen; -1 if it never rises
    task automatic wait_out(output int lat);
        int found;
        found = 0;
        lat   = 1;
        for (int c = 0; c < 20; c++) begin
            if (bus.oValid === 1'b1) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (found == 0) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.iReady = 1'b1;
        @(posedge clk);
        #1;
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.oValid !== 1'b0)    begin n_err++; $display("FAIL reset_oValid got=%b want=0", bus.oValid); end
        n_cmp++; if (bus.oNum !== 8'h00)     begin n_err++; $display("FAIL reset_oNum got=%h want=00", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL reset_oOverflow got=%b want=0", bus.oOverflow); end
        n_cmp++; if (bus.oReady !== 1'b1)    begin n_err++; $display("FAIL reset_oReady got=%b want=1", bus.oReady); end
    endtask

    // 1.0 + 1.0 = 2.0 -> 0x40
    task automatic test_basic_sum();
        int lat;
        beat(8'h38, 1'b0, 1'b0);
        beat(8'h38, 1'b0, 1'b1);
        n_cmp++; if (bus.oReady !== 1'b0)    begin n_err++; $display("FAIL basic_norm_oReady got=%b want=0", bus.oReady); end
        wait_out(lat);
        n_cmp++; if (lat !== 2)              begin n_err++; $display("FAIL basic_latency got=%0d want=2", lat); end
        n_cmp++; if (bus.oNum !== 8'h40)     begin n_err++; $display("FAIL basic_oNum got=%h want=40", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL basic_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
        n_cmp++; if (bus.oValid !== 1'b0)    begin n_err++; $display("FAIL basic_after_oValid got=%b want=0", bus.oValid); end
        n_cmp++; if (bus.oReady !== 1'b1)    begin n_err++; $display("FAIL basic_after_oReady got=%b want=1", bus.oReady); end
    endtask

    // 1.0 - 1.0 = 0; negative zero alone = 0
    task automatic test_cancel();
        int lat;
        beat(8'h38, 1'b0, 1'b0);
        beat(8'hB8, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (lat !== 2)              begin n_err++; $display("FAIL cancel_latency got=%0d want=2", lat); end
        n_cmp++; if (bus.oNum !== 8'h00)     begin n_err++; $display("FAIL cancel_oNum got=%h want=00", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL cancel_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
        beat(8'h80, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h00)     begin n_err++; $display("FAIL negzero_oNum got=%h want=00", bus.oNum); end
        consume();
    endtask

    // 3 x 480 = 1440 exceeds 480 max -> clamp; next sum sees a cleared sticky flag
    task automatic test_overflow();
        int lat;
        beat(8'h7F, 1'b0, 1'b0);
        beat(8'h7F, 1'b0, 1'b0);
        beat(8'h7F, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h7F)     begin n_err++; $display("FAIL ovf_oNum got=%h want=7f", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b1) begin n_err++; $display("FAIL ovf_oOverflow got=%b want=1", bus.oOverflow); end
        consume();
        beat(8'h38, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h38)     begin n_err++; $display("FAIL ovf_clear_oNum got=%h want=38", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
        // single largest term 480 is still representable
        beat(8'h7F, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h7F)     begin n_err++; $display("FAIL maxterm_oNum got=%h want=7f", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL maxterm_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
    endtask

    // 1.015625 truncates to 1.0; an iOvf beat forces clamp
    task automatic test_trunc_and_iovf();
        int lat;
        beat(8'h38, 1'b0, 1'b0);
        beat(8'h08, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h38)     begin n_err++; $display("FAIL trunc_oNum got=%h want=38", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL trunc_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
        beat(8'h38, 1'b1, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h7F)     begin n_err++; $display("FAIL iovf_oNum got=%h want=7f", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b1) begin n_err++; $display("FAIL iovf_oOverflow got=%b want=1", bus.oOverflow); end
        consume();
    endtask

    // Tiny results: 10/1024 - 9/1024 = 1/1024 flushes; smallest term 9/1024 -> 0x01
    task automatic test_underflow();
        int lat;
        beat(8'h02, 1'b0, 1'b0);
        beat(8'h81, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h00)     begin n_err++; $display("FAIL uflow_oNum got=%h want=00", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL uflow_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
        beat(8'h01, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h01)     begin n_err++; $display("FAIL minterm_oNum got=%h want=01", bus.oNum); end
        consume();
    endtask

    // Negative results; saturating negative run clamps to -max (or zero with ReLU, flag kept)
    task automatic test_sign();
        int         lat;
        logic [7:0] exp_neg;
        logic [7:0] exp_sat;
`ifdef FLOAT8_ACC_RELU_EN
        exp_neg = 8'h00;
        exp_sat = 8'h00;
`else
        exp_neg = 8'hC0;
        exp_sat = 8'hFF;
`endif
        beat(8'hC0, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== exp_neg)   begin n_err++; $display("FAIL neg_oNum got=%h want=%h", bus.oNum, exp_neg); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL neg_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
        for (int k = 0; k < 20; k++) beat(8'hFF, 1'b0, (k == 19));
        wait_out(lat);
        n_cmp++; if (bus.oNum !== exp_sat)   begin n_err++; $display("FAIL negsat_oNum got=%h want=%h", bus.oNum, exp_sat); end
        n_cmp++; if (bus.oOverflow !== 1'b1) begin n_err++; $display("FAIL negsat_oOverflow got=%b want=1", bus.oOverflow); end
        consume();
    endtask

    // Result held while the consumer stalls; offered terms must not leak into the next sum
    task automatic test_hold();
        int lat;
        beat(8'h38, 1'b0, 1'b1);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.iValid = 1'b1;
            bus.iNum   = 8'h7F;
            bus.iLast  = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++; if (bus.oValid !== 1'b1) begin n_err++; $display("FAIL hold_oValid[%0d] got=%b want=1", c, bus.oValid); end
            n_cmp++; if (bus.oNum !== 8'h38)  begin n_err++; $display("FAIL hold_oNum[%0d] got=%h want=38", c, bus.oNum); end
            n_cmp++; if (bus.oReady !== 1'b0) begin n_err++; $display("FAIL hold_oReady[%0d] got=%b want=0", c, bus.oReady); end
        end
        bus.iValid = 1'b0;
        bus.iLast  = 1'b0;
        consume();
        beat(8'h38, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (bus.oNum !== 8'h38)     begin n_err++; $display("FAIL hold_next_oNum got=%h want=38", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL hold_next_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
    endtask

    // Reset with an overflowing partial sum in flight; next sum starts clean
    task automatic test_reset_mid_sum();
        int lat;
        beat(8'h7F, 1'b0, 1'b0);
        beat(8'h7F, 1'b1, 1'b0);
        beat(8'h7F, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.oValid !== 1'b0)    begin n_err++; $display("FAIL midrst_oValid got=%b want=0", bus.oValid); end
        n_cmp++; if (bus.oNum !== 8'h00)     begin n_err++; $display("FAIL midrst_oNum got=%h want=00", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL midrst_oOverflow got=%b want=0", bus.oOverflow); end
        n_cmp++; if (bus.oReady !== 1'b1)    begin n_err++; $display("FAIL midrst_oReady got=%b want=1", bus.oReady); end
        beat(8'h38, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (lat !== 2)              begin n_err++; $display("FAIL midrst_latency got=%0d want=2", lat); end
        n_cmp++; if (bus.oNum !== 8'h38)     begin n_err++; $display("FAIL midrst_next_oNum got=%h want=38", bus.oNum); end
        n_cmp++; if (bus.oOverflow !== 1'b0) begin n_err++; $display("FAIL midrst_next_oOverflow got=%b want=0", bus.oOverflow); end
        consume();
    endtask

    initial begin
        rst        = 1'b1;
        bus.iValid = 1'b0;
        bus.iNum   = 8'h00;
        bus.iOvf   = 1'b0;
        bus.iLast  = 1'b0;
        bus.iReady = 1'b0;
        test_reset();
        test_basic_sum();
        test_cancel();
        test_overflow();
        test_trunc_and_iovf();
        test_underflow();
        test_sign();
        test_hold();
        test_reset_mid_sum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
